flash_op_seq: RTL and testbench
===============================

// Module: flash_op_seq
// PURPOSE
//  Operation sequencer placed above the SPI flash command engine (spi_flash/spi_dri).
//  Turns one user request (read, page program, sector erase, chip erase) into the full command chain:
//  - WREN (0x06) before program/erase;
//  - the operation itself;
//  - RDSR (0x05) polling until WIP (bit0) clears.
//  Key-driven or user logic no longer issues WREN or checks busy by hand.
// PARAMETERS
//  POLL_GAP   16    idle clk cycles between end of one RDSR and start of the next (>=1)
//  MAX_POLLS  4096  RDSR attempts before timeout error (only used with FLASH_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  req          in   1   1-cycle request strobe; accepted only when busy==0
//  req_op       in   2   0=read(0x03) 1=page program(0x02) 2=sector erase(0x20) 3=chip erase(0xC7)
//  req_addr     in   24  flash byte address (ignored for chip erase)
//  req_len      in   8   byte count for read/program; ignored for erase
//  req_wdata    in   8   program data byte (passed through to engine)
//  busy         out  1   high from accept cycle until op_done cycle inclusive
//  op_done      out  1   1-cycle pulse at end of sequence
//  op_err       out  1   sticky timeout flag; cleared on next accepted req
//  status       out  8   last status byte read by RDSR
//  flash_start  out  1   1-cycle start pulse to command engine
//  flash_cmd    out  8   command byte, held stable while engine runs
//  flash_addr   out  24  address, held stable
//  flash_num    out  8   data byte count for engine (0 = cmd/addr only)
//  flash_wdata  out  8   write byte to engine
//  flash_done   in   1   1-cycle pulse: engine finished whole transaction (CS released)
//  flash_rdata  in   8   read byte from engine
//  flash_rvalid in   1   1-cycle pulse: flash_rdata valid
// BEHAVIOUR
//  Reset: state IDLE; busy=0, op_done=0, op_err=0, status=0, flash_start=0,
//         flash_cmd=0, flash_addr=0, flash_num=0, flash_wdata=0.
//  Accept: req && !busy in IDLE -> latch op/addr/len/wdata; busy=1 next cycle; clear op_err.
//  req while busy ignored (no queue).
//  States / transitions:
//   IDLE   -- accept, op==0 -> CMD(0x03, addr, len); op!=0 -> WREN
//   WREN   -- flash_start=1 with cmd 0x06, num 0 -> WWAIT
//   WWAIT  -- flash_done -> CMD
//   CMD    -- flash_start=1 with cmd/addr/num per op (erase num=0; chip erase addr=0) -> CWAIT
//   CWAIT  -- flash_done: read -> DONE; else -> GAP
//   GAP    -- count POLL_GAP cycles -> POLL
//   POLL   -- flash_start=1 cmd 0x05, addr 0, num 1 -> PWAIT
//   PWAIT  -- flash_rvalid: status<=flash_rdata; on flash_done: status[0]==1 -> GAP; else -> DONE
//   DONE   -- op_done=1 for one cycle, busy=0 next cycle -> IDLE
//  flash_start: exactly one cycle per engine transaction.
//  Never reasserted before flash_done of the previous transaction.
//  flash_cmd/addr/num/wdata update in the same cycle as flash_start; held until the next start.
//  Read latency: accept -> flash_start 1 cycle; op_done 1 cycle after flash_done.
//  Poll counter: 16-bit, reset on accept, +1 per RDSR issued; saturates at 16'hFFFF.
//  Spurious flash_done/flash_rvalid in IDLE/WREN/CMD/GAP/DONE: ignored.
//  flash_done and flash_rvalid in the same PWAIT cycle: status is captured first,
//  and the branch uses the new byte.
//  Reset mid-operation: immediate return to IDLE; no trailing flash_start is issued.
// CONFIGURATION
//  FLASH_SEQ_TIMEOUT_EN defined:
//   - when the poll count reaches MAX_POLLS and WIP is still 1 at flash_done, go to DONE;
//   - op_done pulses and op_err=1.
//  FLASH_SEQ_TIMEOUT_EN undefined:
//   - polling is unbounded; op_err is tied 0;
//   - MAX_POLLS unused; no comparator logic.
// TESTING
//  1 Read: req op=0 addr=0x000030 len=20 -> one start, cmd 0x03 addr 0x000030 num 20;
//    op_done 1 cycle after flash_done; no 0x06 and no 0x05 issued.
//  2 Program, WIP model busy for 3 polls: req op=1 len=10 wdata=0x5A
//    -> start sequence 06, 02(num 10), 05 x4;
//    status final 0x00; op_done once; each poll gap >= POLL_GAP cycles.
//  3 Sector erase addr=0x001000
//    -> 06 then 20 with addr 0x001000 num 0, then polls;
//    chip erase -> C7 with addr 0.
//  4 req pulsed while busy (mid CWAIT) -> ignored.
//    Original op completes unchanged; a new req after op_done is accepted.
//  5 rst_n low during GAP of erase -> all outputs at reset values next edge.
//    No flash_start until a new req.
//  6 TIMEOUT_EN, MAX_POLLS=4, WIP stuck 1 -> exactly 4 RDSR starts, op_done with op_err=1.
//    Next req clears op_err. Without the macro: polling continues past 4, op_err stays 0.

Source files
------------

// File: rtl/flash_op_seq.sv
// Sequencer above the SPI flash command engine: WREN, operation, then RDSR polling until WIP clears.
// Optional poll timeout with op_err is compiled in with `define FLASH_SEQ_TIMEOUT_EN.
module flash_op_seq #(
  parameter int unsigned POLL_GAP  = 16,
  parameter int unsigned MAX_POLLS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        op_done,
  output logic        op_err,
  output logic [7:0]  status,
  output logic        flash_start,
  output logic [7:0]  flash_cmd,
  output logic [23:0] flash_addr,
  output logic [7:0]  flash_num,
  output logic [7:0]  flash_wdata,
  input  logic        flash_done,
  input  logic [7:0]  flash_rdata,
  input  logic        flash_rvalid
);

  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_PROG = 2'd1;
  localparam logic [1:0] OP_SECT = 2'd2;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PROG = 8'h02;
  localparam logic [7:0] CMD_SECT = 8'h20;
  localparam logic [7:0] CMD_CHIP = 8'hC7;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_WWAIT, S_CMD, S_CWAIT, S_GAP, S_POLL, S_PWAIT, S_DONE
  } state_t;

  state_t          state_q;
  logic            busy_q, op_done_q, start_q;
  logic [7:0]      status_q, cmd_q, num_q, wdata_q;
  logic [23:0]     addr_q;
  logic [1:0]      op_q;
  logic [23:0]     lat_addr_q;
  logic [7:0]      lat_len_q, lat_wdata_q;
  logic [GW-1:0]   gap_q;
  logic [7:0]      op_cmd;
  logic            accept, wip_now, timeout;

  assign accept  = (state_q == S_IDLE) && req && !busy_q;
  // A status byte arriving with flash_done decides the branch itself.
  assign wip_now = flash_rvalid ? flash_rdata[0] : status_q[0];

  always_comb begin
    op_cmd = CMD_READ;
    case (op_q)
      OP_READ: op_cmd = CMD_READ;
      OP_PROG: op_cmd = CMD_PROG;
      OP_SECT: op_cmd = CMD_SECT;
      default: op_cmd = CMD_CHIP;
    endcase
  end

`ifdef FLASH_SEQ_TIMEOUT_EN
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        op_err_q;

  assign poll_cnt_d = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
  assign timeout    = (poll_cnt_q >= 16'(MAX_POLLS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt_q <= '0;
      op_err_q   <= 1'b0;
    end else if (accept) begin
      poll_cnt_q <= '0;
      op_err_q   <= 1'b0;
    end else begin
      if (state_q == S_POLL) poll_cnt_q <= poll_cnt_d;
      if (state_q == S_PWAIT && flash_done && wip_now && timeout) op_err_q <= 1'b1;
    end
  end

  assign op_err = op_err_q;
`else
  // MAX_POLLS only matters when the timeout is compiled in.
  logic unused_cfg;
  assign unused_cfg = ^32'(MAX_POLLS);
  assign timeout    = 1'b0;
  assign op_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      op_done_q   <= 1'b0;
      start_q     <= 1'b0;
      status_q    <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      num_q       <= '0;
      wdata_q     <= '0;
      op_q        <= '0;
      lat_addr_q  <= '0;
      lat_len_q   <= '0;
      lat_wdata_q <= '0;
      gap_q       <= '0;
    end else begin
      start_q   <= 1'b0;
      op_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          op_q        <= req_op;
          lat_addr_q  <= req_addr;
          lat_len_q   <= req_len;
          lat_wdata_q <= req_wdata;
          busy_q      <= 1'b1;
          state_q     <= (req_op == OP_READ) ? S_CMD : S_WREN;
        end
        S_WREN: begin
          start_q <= 1'b1;
          cmd_q   <= CMD_WREN;
          addr_q  <= '0;
          num_q   <= '0;
          state_q <= S_WWAIT;
        end
        S_WWAIT: if (flash_done) state_q <= S_CMD;
        S_CMD: begin
          start_q <= 1'b1;
          cmd_q   <= op_cmd;
          addr_q  <= (op_q == OP_READ || op_q == OP_PROG || op_q == OP_SECT) ? lat_addr_q : '0;
          num_q   <= (op_q == OP_READ || op_q == OP_PROG) ? lat_len_q : '0;
          wdata_q <= lat_wdata_q;
          state_q <= S_CWAIT;
        end
        S_CWAIT: if (flash_done) begin
          if (op_q == OP_READ) begin
            op_done_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            gap_q   <= GAP_LOAD;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == '0) state_q <= S_POLL;
          else             gap_q   <= gap_q - 1'b1;
        end
        S_POLL: begin
          start_q <= 1'b1;
          cmd_q   <= CMD_RDSR;
          addr_q  <= '0;
          num_q   <= 8'd1;
          state_q <= S_PWAIT;
        end
        S_PWAIT: begin
          if (flash_rvalid) status_q <= flash_rdata;
          if (flash_done) begin
            if (wip_now && !timeout) begin
              gap_q   <= GAP_LOAD;
              state_q <= S_GAP;
            end else begin
              op_done_q <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign op_done     = op_done_q;
  assign status      = status_q;
  assign flash_start = start_q;
  assign flash_cmd   = cmd_q;
  assign flash_addr  = addr_q;
  assign flash_num   = num_q;
  assign flash_wdata = wdata_q;

endmodule

// File: tb/tb_flash_op_seq.sv
// Randomized scoreboard bench for flash_op_seq with a behavioural engine/flash model.
// Expectations follow FLASH_SEQ_TIMEOUT_EN when the bench is compiled with it.
module tb_flash_op_seq;
  localparam int POLL_GAP  = 5;
  localparam int MAX_POLLS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  req_op = '0;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_len = '0, req_wdata = '0;
  logic        busy, op_done, op_err, flash_start;
  logic [7:0]  status, flash_cmd, flash_num, flash_wdata;
  logic [23:0] flash_addr;
  logic        flash_done = 1'b0, flash_rvalid = 1'b0;
  logic [7:0]  flash_rdata = '0;

  always #5 clk = ~clk;

  flash_op_seq #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .busy(busy), .op_done(op_done),
    .op_err(op_err), .status(status), .flash_start(flash_start), .flash_cmd(flash_cmd),
    .flash_addr(flash_addr), .flash_num(flash_num), .flash_wdata(flash_wdata),
    .flash_done(flash_done), .flash_rdata(flash_rdata), .flash_rvalid(flash_rvalid)
  );

  typedef struct packed {
    logic [7:0] cmd; logic [23:0] addr; logic [7:0] num; logic [7:0] wdata; logic chk_wdata;
  } xact_t;
  typedef struct packed { logic [7:0] status; logic err; logic is_read; } done_t;

  xact_t      exp_q[$];
  done_t      done_q[$];
  logic [7:0] sr_q[$];

  int   checks = 0, passes = 0;
  int   cyc = 0, last_done_cyc = -100, req_cyc = 0, done_cnt = 0, start_cnt = 0;
  bit   first_pending = 0, outstanding = 0, spur_en = 0, rand_sr = 0;
  logic [7:0] model_status = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Reference: one request expands into its command list and final result.
  function automatic void model_op(input logic [1:0] op, input logic [23:0] addr,
                                   input logic [7:0] len, input logic [7:0] wd, input int npb);
    int np; bit err; logic [7:0] b;
    if (op == 2'd0) begin
      exp_q.push_back('{8'h03, addr, len, 8'h00, 1'b0});
      done_q.push_back('{model_status, 1'b0, 1'b1});
      return;
    end
    exp_q.push_back('{8'h06, 24'h0, 8'h00, 8'h00, 1'b0});
    case (op)
      2'd1:    exp_q.push_back('{8'h02, addr, len, wd, 1'b1});
      2'd2:    exp_q.push_back('{8'h20, addr, 8'h00, 8'h00, 1'b0});
      default: exp_q.push_back('{8'hC7, 24'h0, 8'h00, 8'h00, 1'b0});
    endcase
    np = npb + 1; err = 0;
`ifdef FLASH_SEQ_TIMEOUT_EN
    if (npb >= MAX_POLLS) begin np = MAX_POLLS; err = 1; end
`endif
    b = '0;
    for (int i = 0; i < np; i++) begin
      b[7:1] = rand_sr ? 7'($urandom) : 7'd0;
      b[0]   = (i < npb);
      sr_q.push_back(b);
      exp_q.push_back('{8'h05, 24'h0, 8'h01, 8'h00, 1'b0});
    end
    model_status = b;
    done_q.push_back('{b, err, 1'b0});
  endfunction

  // Engine model: random transaction length, RDSR byte from sr_q, spurious pulses while idle.
  int eng_cnt = 0; bit eng_busy = 0, eng_sr = 0, eng_rd = 0, eng_split = 0;
  initial forever begin
    @(posedge clk); #1;
    flash_done = 1'b0; flash_rvalid = 1'b0;
    if (!rst_n) eng_busy = 0;
    else if (flash_start) begin
      eng_busy = 1; eng_cnt = $urandom_range(2, 6);
      eng_sr = (flash_cmd == 8'h05); eng_rd = (flash_cmd == 8'h03);
      eng_split = $urandom_range(0, 1);
    end else if (eng_busy) begin
      eng_cnt--;
      if (eng_sr && ((eng_split && eng_cnt == 1) || (!eng_split && eng_cnt == 0))) begin
        flash_rvalid = 1'b1;
        flash_rdata  = (sr_q.size() != 0) ? sr_q.pop_front() : 8'h00;
      end
      if (eng_cnt == 0) begin
        flash_done = 1'b1; eng_busy = 0;
        if (eng_rd) begin flash_rvalid = 1'b1; flash_rdata = 8'($urandom); end
      end
    end else if (spur_en && $urandom_range(0, 4) == 0) begin
      flash_done   = 1'($urandom_range(0, 1));
      flash_rvalid = 1'b1;
      flash_rdata  = 8'($urandom);
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    xact_t e; done_t d;
    if (!rst_n) outstanding = 0;
    else begin
      if (flash_start) begin
        start_cnt++;
        check(!outstanding, "start_overlap", $sformatf("start at cycle %0d before previous done", cyc));
        outstanding = 1;
        check(exp_q.size() != 0, "unexpected_start", $sformatf("cmd %02h got, none expected", flash_cmd));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(flash_cmd == e.cmd && flash_addr == e.addr && flash_num == e.num &&
                (!e.chk_wdata || flash_wdata == e.wdata), "start_fields",
                $sformatf("got cmd %02h addr %06h num %0d wdata %02h, want cmd %02h addr %06h num %0d wdata %02h",
                          flash_cmd, flash_addr, flash_num, flash_wdata, e.cmd, e.addr, e.num, e.wdata));
        end
        if (flash_cmd == 8'h05)
          check(cyc - last_done_cyc - 1 >= POLL_GAP, "poll_gap",
                $sformatf("got %0d idle cycles, want >= %0d", cyc - last_done_cyc - 1, POLL_GAP));
        if (first_pending) begin
          check(cyc == req_cyc + 2, "start_latency",
                $sformatf("got start at cycle %0d, want %0d", cyc, req_cyc + 2));
          first_pending = 0;
        end
      end
      if (flash_done) begin last_done_cyc = cyc; outstanding = 0; end
      if (op_done) begin
        check(done_q.size() != 0, "unexpected_done", $sformatf("op_done at cycle %0d", cyc));
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          check(status == d.status && op_err == d.err, "done_result",
                $sformatf("got status %02h err %0b, want status %02h err %0b", status, op_err, d.status, d.err));
          check(exp_q.size() == 0, "missing_starts", $sformatf("got %0d starts still pending, want 0", exp_q.size()));
          if (d.is_read)
            check(cyc == last_done_cyc + 1, "read_done_latency",
                  $sformatf("got op_done at cycle %0d, want %0d", cyc, last_done_cyc + 1));
        end
        done_cnt++;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] len,
                       input logic [7:0] wd, input int npb);
    model_op(op, addr, len, wd, npb);
    spur_en = 0;
    @(posedge clk); #1;
    req = 1'b1; req_op = op; req_addr = addr; req_len = len; req_wdata = wd;
    req_cyc = cyc; first_pending = 1;
    @(posedge clk); #1;
    req = 1'b0; req_op = 2'($urandom); req_addr = 24'($urandom); req_len = 8'($urandom); req_wdata = 8'($urandom);
    check(busy == 1'b1, "busy_after_accept", $sformatf("got busy %0b, want 1", busy));
  endtask

  task automatic do_op(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] len,
                       input logic [7:0] wd, input int npb, input bit interfere);
    int c0;
    c0 = done_cnt;
    issue(op, addr, len, wd, npb);
    if (interfere) begin
      for (int i = 0; i < 200 && first_pending; i++) @(posedge clk);
      #1;
      req = 1'b1; req_op = 2'($urandom); req_addr = 24'($urandom); req_len = 8'($urandom);
      @(posedge clk); #1;
      req = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == c0; i++) @(posedge clk);
    #1;
    check(done_cnt != c0, "op_done_timeout", $sformatf("op %0d: got no op_done, want one", op));
    check(busy == 1'b0, "busy_release", $sformatf("got busy %0b after op_done, want 0", busy));
    spur_en = 1;
    repeat ($urandom_range(2, 6)) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({busy, op_done, op_err, status, flash_start, flash_cmd, flash_addr, flash_num, flash_wdata} == '0,
          name, $sformatf("got busy %0b done %0b err %0b status %02h start %0b cmd %02h addr %06h num %0d wdata %02h, want all 0",
                          busy, op_done, op_err, status, flash_start, flash_cmd, flash_addr, flash_num, flash_wdata));
  endtask

  initial begin
    int s0;
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_op(2'd0, 24'h000030, 8'd20, 8'h00, 0, 0);
    do_op(2'd1, 24'h012345, 8'd10, 8'h5A, 3, 0);
    do_op(2'd2, 24'h001000, 8'd7, 8'h00, 2, 0);
    do_op(2'd3, 24'hABCDEF, 8'd9, 8'h00, 1, 0);
    do_op(2'd0, 24'h000100, 8'd4, 8'h00, 0, 1);
    do_op(2'd1, 24'h000200, 8'd3, 8'hC3, 0, 1);

    // Reset while the erase sits in its poll gap.
    issue(2'd2, 24'h002000, 8'd0, 8'h00, 3);
    for (int i = 0; i < 300 && !(exp_q.size() == 4 && !outstanding); i++) @(posedge clk);
    #1; rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid_op");
    exp_q.delete(); done_q.delete(); sr_q.delete();
    model_status = '0; first_pending = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    s0 = start_cnt; spur_en = 1;
    repeat (40) @(posedge clk);
    check(start_cnt == s0, "no_start_after_reset", $sformatf("got %0d starts, want 0", start_cnt - s0));

    // WIP stuck beyond MAX_POLLS.
    do_op(2'd1, 24'h003000, 8'd2, 8'h11, 6, 0);
`ifdef FLASH_SEQ_TIMEOUT_EN
    check(op_err == 1'b1, "err_sticky", $sformatf("got op_err %0b while idle, want 1", op_err));
`else
    check(op_err == 1'b0, "err_tied", $sformatf("got op_err %0b, want 0", op_err));
`endif
    do_op(2'd0, 24'h000040, 8'd1, 8'h00, 0, 0);

    rand_sr = 1;
    for (int n = 0; n < 25; n++)
      do_op(2'($urandom_range(0, 3)), 24'($urandom), 8'($urandom_range(1, 255)), 8'($urandom),
            $urandom_range(0, 5), $urandom_range(0, 3) == 0);

    check(exp_q.size() == 0 && done_q.size() == 0, "scoreboard_drained",
          $sformatf("got %0d starts and %0d dones pending, want 0", exp_q.size(), done_q.size()));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end
endmodule
